// File: rtl/cu_vertex_cache_response_merge_if.sv
// Packet types and the bus interface for the vertex-cache response merge.
// The optional statistics outputs exist only when CU_VERTEX_MERGE_STATS_EN is defined.
package cu_vertex_merge_pkg;
  typedef struct packed {
    logic        valid;
    logic [7:0]  cu_id;
    logic [15:0] tag;
  } ResponseBufferLine;

  typedef struct packed {
    logic [63:0] data;
  } ReadWriteDataLine;

  typedef struct packed {
    logic        valid;
    logic [31:0] address;
    logic [15:0] tag;
  } CommandBufferLine;

  typedef struct packed {
    ResponseBufferLine response;
    ReadWriteDataLine  data_0;
    ReadWriteDataLine  data_1;
  } MergePacket;
endpackage

interface cu_vertex_cache_response_merge_if #(
  parameter int OUTSTANDING_BITS = 8
);
  import cu_vertex_merge_pkg::*;

  logic                        enabled_in;
  ResponseBufferLine           cache_response_in;
  ReadWriteDataLine            cache_data_0_in;
  ReadWriteDataLine            cache_data_1_in;
  CommandBufferLine            miss_command_in;
  ResponseBufferLine           mem_response_in;
  ReadWriteDataLine            mem_data_0_in;
  ReadWriteDataLine            mem_data_1_in;
  ResponseBufferLine           read_response_out;
  ReadWriteDataLine            read_data_0_out;
  ReadWriteDataLine            read_data_1_out;
  logic                        cache_almost_full_out;
  logic                        mem_almost_full_out;
  logic [OUTSTANDING_BITS-1:0] outstanding_misses_out;
  logic                        overflow_error_out;
`ifdef CU_VERTEX_MERGE_STATS_EN
  logic [31:0]                 hit_count_out;
  logic [31:0]                 fill_count_out;
`endif

  modport master (
    output enabled_in, cache_response_in, cache_data_0_in, cache_data_1_in,
    output miss_command_in, mem_response_in, mem_data_0_in, mem_data_1_in,
    input  read_response_out, read_data_0_out, read_data_1_out,
    input  cache_almost_full_out, mem_almost_full_out, outstanding_misses_out,
    input  overflow_error_out
`ifdef CU_VERTEX_MERGE_STATS_EN
    , input hit_count_out, fill_count_out
`endif
  );

  modport slave (
    input  enabled_in, cache_response_in, cache_data_0_in, cache_data_1_in,
    input  miss_command_in, mem_response_in, mem_data_0_in, mem_data_1_in,
    output read_response_out, read_data_0_out, read_data_1_out,
    output cache_almost_full_out, mem_almost_full_out, outstanding_misses_out,
    output overflow_error_out
`ifdef CU_VERTEX_MERGE_STATS_EN
    , output hit_count_out, fill_count_out
`endif
  );
endinterface

// File: rtl/cu_vertex_cache_response_merge.sv
// Merges cache-hit and memory-fill packets into one response stream: registered inputs, per-source FIFOs,
// round-robin arbiter (3-cycle latency), outstanding-miss tracking. CU_VERTEX_MERGE_STATS_EN adds hit/fill counters.
module cu_vertex_merge_fifo #(
  parameter int DEPTH  = 16,
  parameter int AF_LVL = 12,
  parameter int WIDTH  = 8
) (
  input  logic             clock,
  input  logic             rstn_in,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic             not_empty,
  output logic             almost_full,
  output logic             accepted,
  output logic             dropped
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             full;
  logic             pop_ok;

  assign full        = (count == CW'(DEPTH));
  assign not_empty   = (count != '0);
  assign pop_ok      = pop && not_empty;
  // A pop frees the slot in the same cycle, so a push into a full FIFO is still taken then.
  assign accepted    = push && (!full || pop_ok);
  assign dropped     = push && full && !pop_ok;
  assign almost_full = (count >= CW'(AF_LVL));
  assign pop_dat     = mem[rd_ptr];

  always_ff @(posedge clock or negedge rstn_in) begin
    if (!rstn_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accepted) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)   rd_ptr <= rd_ptr + AW'(1);
      if (accepted && !pop_ok)      count <= count + CW'(1);
      else if (!accepted && pop_ok) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (accepted) mem[wr_ptr] <= push_dat;
  end
endmodule

module cu_vertex_cache_response_merge
  import cu_vertex_merge_pkg::*;
#(
  parameter int FIFO_DEPTH       = 16,
  parameter int ALMOST_FULL_LVL  = 12,
  parameter int OUTSTANDING_BITS = 8
) (
  input  logic                             clock,
  input  logic                             rstn_in,
  cu_vertex_cache_response_merge_if.slave  bus
);
  localparam int PW = $bits(MergePacket);
  localparam logic [OUTSTANDING_BITS-1:0] OUT_MAX = '1;

  typedef enum logic {GRANT_CACHE, GRANT_MEM} grant_e;

  MergePacket                  cache_pkt_q, mem_pkt_q, out_pkt_q;
  MergePacket                  cache_head, mem_head;
  logic                        miss_vld_q, en_q;
  logic                        cache_ne, mem_ne, cache_af, mem_af;
  logic                        cache_acc, mem_acc, cache_drop, mem_drop;
  logic                        grant_cache, grant_mem, fill_vld, cnt_err;
  logic [OUTSTANDING_BITS-1:0] outstanding_q;
  logic                        overflow_q;
  grant_e                      last_grant;

  always_ff @(posedge clock or negedge rstn_in) begin
    if (!rstn_in) begin
      cache_pkt_q <= '0;
      mem_pkt_q   <= '0;
      miss_vld_q  <= 1'b0;
      en_q        <= 1'b0;
    end else begin
      cache_pkt_q <= {bus.cache_response_in, bus.cache_data_0_in, bus.cache_data_1_in};
      mem_pkt_q   <= {bus.mem_response_in, bus.mem_data_0_in, bus.mem_data_1_in};
      miss_vld_q  <= bus.miss_command_in.valid;
      en_q        <= bus.enabled_in;
    end
  end

  cu_vertex_merge_fifo #(.DEPTH(FIFO_DEPTH), .AF_LVL(ALMOST_FULL_LVL), .WIDTH(PW)) u_cache_fifo (
    .clock(clock), .rstn_in(rstn_in),
    .push(cache_pkt_q.response.valid), .push_dat(cache_pkt_q),
    .pop(grant_cache), .pop_dat(cache_head),
    .not_empty(cache_ne), .almost_full(cache_af), .accepted(cache_acc), .dropped(cache_drop)
  );

  cu_vertex_merge_fifo #(.DEPTH(FIFO_DEPTH), .AF_LVL(ALMOST_FULL_LVL), .WIDTH(PW)) u_mem_fifo (
    .clock(clock), .rstn_in(rstn_in),
    .push(mem_pkt_q.response.valid), .push_dat(mem_pkt_q),
    .pop(grant_mem), .pop_dat(mem_head),
    .not_empty(mem_ne), .almost_full(mem_af), .accepted(mem_acc), .dropped(mem_drop)
  );

  // With both sources pending, the one not served last wins.
  assign grant_cache = en_q && cache_ne && (!mem_ne || last_grant == GRANT_MEM);
  assign grant_mem   = en_q && mem_ne && (!cache_ne || last_grant == GRANT_CACHE);

  always_ff @(posedge clock or negedge rstn_in) begin
    if (!rstn_in) begin
      last_grant <= GRANT_MEM;
      out_pkt_q  <= '0;
    end else if (grant_cache) begin
      last_grant <= GRANT_CACHE;
      out_pkt_q  <= cache_head;
    end else if (grant_mem) begin
      last_grant <= GRANT_MEM;
      out_pkt_q  <= mem_head;
    end else begin
      out_pkt_q  <= '0;
    end
  end

  assign fill_vld = mem_pkt_q.response.valid;
  assign cnt_err  = (miss_vld_q && !fill_vld && outstanding_q == OUT_MAX) ||
                    (fill_vld && !miss_vld_q && outstanding_q == '0);

  always_ff @(posedge clock or negedge rstn_in) begin
    if (!rstn_in) begin
      outstanding_q <= '0;
      overflow_q    <= 1'b0;
    end else begin
      if (miss_vld_q && !fill_vld) begin
        if (outstanding_q != OUT_MAX) outstanding_q <= outstanding_q + 1'b1;
      end else if (fill_vld && !miss_vld_q) begin
        if (outstanding_q != '0) outstanding_q <= outstanding_q - 1'b1;
      end
      if (cache_drop || mem_drop || cnt_err) overflow_q <= 1'b1;
    end
  end

  assign bus.read_response_out      = out_pkt_q.response;
  assign bus.read_data_0_out        = out_pkt_q.data_0;
  assign bus.read_data_1_out        = out_pkt_q.data_1;
  assign bus.cache_almost_full_out  = cache_af;
  assign bus.mem_almost_full_out    = mem_af;
  assign bus.outstanding_misses_out = outstanding_q;
  assign bus.overflow_error_out     = overflow_q;

  wire unused_miss_fields = &{1'b0, bus.miss_command_in.address, bus.miss_command_in.tag};

`ifdef CU_VERTEX_MERGE_STATS_EN
  logic [31:0] hit_count_q, fill_count_q;

  always_ff @(posedge clock or negedge rstn_in) begin
    if (!rstn_in) begin
      hit_count_q  <= '0;
      fill_count_q <= '0;
    end else begin
      if (cache_acc) hit_count_q  <= hit_count_q + 32'd1;
      if (mem_acc)   fill_count_q <= fill_count_q + 32'd1;
    end
  end

  assign bus.hit_count_out  = hit_count_q;
  assign bus.fill_count_out = fill_count_q;
`else
  wire unused_accept = &{1'b0, cache_acc, mem_acc};
`endif
endmodule
